// File: rtl/spi_oled_tx_fifo.sv
// spi_oled_tx_fifo
// ----------------
// SPI MOSI-only transmitter for the OLED display path, fed by a DEPTH-entry FIFO
// of {DC, DATA} words. SCK is generated from i_CLK with a divider. The mode is
// CPOL-selectable with CPHA fixed at 0: MOSI changes on the trailing SCK edge and
// the slave samples on the leading edge. Queued words go out back-to-back under
// one CS assertion with no SCK gap.
//
// Optional build macro:
//   SPI_TX_CS_PER_WORD_EN - every word gets its own CS window. CS is released
//                           after each word and held high for CLK_DIV cycles
//                           before the next word is loaded.
//
// Ports:
//   i_CLK   system clock; all logic runs on its rising edge
//   i_RST   asynchronous, active-high reset
//   i_DATA  word to transmit (WIDTH bits)
//   i_DC    data/command flag travelling with the word
//   i_VALID push request; accepted when i_VALID && o_READY
//   o_READY FIFO not full (derived from the registered count)
//   o_SCK   serial clock, idles at CPOL
//   o_MOSI  serial data
//   o_CS    chip select, active low
//   o_DC    DC flag of the word currently on the wire
//   o_BUSY  FSM not idle or FIFO non-empty
//   o_DONE  one-cycle pulse after the last bit of each word
module spi_oled_tx_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1,
  parameter int CPOL      = 0
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [WIDTH-1:0] i_DATA,
  input  logic             i_DC,
  input  logic             i_VALID,
  output logic             o_READY,
  output logic             o_SCK,
  output logic             o_MOSI,
  output logic             o_CS,
  output logic             o_DC,
  output logic             o_BUSY,
  output logic             o_DONE
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH);
  localparam logic             SCK_IDLE = (CPOL != 0);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  // ---------------------------------------------------------------------------
  // FIFO of {dc, data}
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [WIDTH:0]   head;
  logic             head_first;

  // A push while full is dropped even if a pop happens in the same cycle,
  // because ready comes from the registered count only.
  assign o_READY    = (count != FULL_CNT);
  assign push       = i_VALID && o_READY;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign head_first = (MSB_FIRST != 0) ? head[WIDTH-1] : head[0];

  // NOTE: storage has no reset; validity is tracked by count/pointers, so the
  // array can map onto plain RAM without a reset network.
  always_ff @(posedge i_CLK) begin
    if (push) mem[wr_ptr] <= {i_DC, i_DATA};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             sck;
  logic             mosi;
  logic             cs;
  logic             dc;
  logic             done;
  logic             half_tick;
  logic             word_end;
  logic             idle_load;

  // half_tick marks the cycle in which SCK toggles; word_end is the trailing
  // edge that completes the last bit of the current word.
  assign half_tick = (state == SHIFT) && (div_cnt == DIV_LAST);
  assign word_end  = half_tick && (sck != SCK_IDLE) && (bit_cnt == BIT_LAST);

`ifdef SPI_TX_CS_PER_WORD_EN
  // Counts CS-high cycles in IDLE so CS stays released for CLK_DIV cycles
  // between words. It starts saturated so the first word after reset is not
  // delayed.
  logic [DIV_W-1:0] idle_cnt;

  assign idle_load = (state == IDLE) && !fifo_empty && (idle_cnt == DIV_LAST);
  assign pop       = idle_load;
`else
  assign idle_load = (state == IDLE) && !fifo_empty;
  assign pop       = idle_load || (word_end && !fifo_empty);
`endif

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      sck      <= SCK_IDLE;
      mosi     <= 1'b0;
      cs       <= 1'b1;
      dc       <= 1'b0;
      done     <= 1'b0;
`ifdef SPI_TX_CS_PER_WORD_EN
      idle_cnt <= DIV_LAST;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
`ifdef SPI_TX_CS_PER_WORD_EN
          if (idle_cnt != DIV_LAST) idle_cnt <= idle_cnt + DIV_W'(1);
`endif
          if (idle_load) begin
            shreg   <= head[WIDTH-1:0];
            mosi    <= head_first;
            dc      <= head[WIDTH];
            bit_cnt <= '0;
            div_cnt <= '0;
            cs      <= 1'b0;
            state   <= SETUP;
          end
        end

        // CS-to-first-edge setup time.
        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        SHIFT: begin
          if (!half_tick) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (sck == SCK_IDLE) begin
              // Leading edge: the slave samples the bit already on MOSI.
              sck     <= ~SCK_IDLE;
              bit_cnt <= bit_cnt + BIT_W'(1);
            end else begin
              sck <= SCK_IDLE;
              if (bit_cnt != BIT_LAST) begin
                if (MSB_FIRST != 0) begin
                  shreg <= {shreg[WIDTH-2:0], 1'b0};
                  mosi  <= shreg[WIDTH-2];
                end else begin
                  shreg <= {1'b0, shreg[WIDTH-1:1]};
                  mosi  <= shreg[1];
                end
              end else begin
                done <= 1'b1;
`ifdef SPI_TX_CS_PER_WORD_EN
                state <= GAP;
`else
                // Back-to-back reload on the same trailing edge keeps SCK
                // periodic across word boundaries.
                if (!fifo_empty) begin
                  shreg   <= head[WIDTH-1:0];
                  mosi    <= head_first;
                  dc      <= head[WIDTH];
                  bit_cnt <= '0;
                end else begin
                  state <= GAP;
                end
`endif
              end
            end
          end
        end

        // CS hold time after the last trailing edge; MOSI is held.
        GAP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            cs       <= 1'b1;
            state    <= IDLE;
`ifdef SPI_TX_CS_PER_WORD_EN
            idle_cnt <= '0;
`endif
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign o_SCK  = sck;
  assign o_MOSI = mosi;
  assign o_CS   = cs;
  assign o_DC   = dc;
  assign o_DONE = done;
  assign o_BUSY = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_spi_oled_tx_fifo.sv
// Testbench for spi_oled_tx_fifo.
// Instance a: default build (WIDTH=8, DEPTH=4, CLK_DIV=2, MSB first, CPOL=0).
// Instance b: WIDTH=16, LSB first, CPOL=1.
// Expected words and bits are queued by the stimulus; slave-model monitors pop
// them as they sample MOSI on the leading SCK edges.
module tb_spi_oled_tx_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Instance a
  logic [7:0] a_data  = '0;
  logic       a_dc    = 1'b0;
  logic       a_valid = 1'b0;
  logic a_ready, a_sck, a_mosi, a_cs, a_dco, a_busy, a_done;

  spi_oled_tx_fifo u_dut_a (
    .i_CLK   (clk),
    .i_RST   (rst),
    .i_DATA  (a_data),
    .i_DC    (a_dc),
    .i_VALID (a_valid),
    .o_READY (a_ready),
    .o_SCK   (a_sck),
    .o_MOSI  (a_mosi),
    .o_CS    (a_cs),
    .o_DC    (a_dco),
    .o_BUSY  (a_busy),
    .o_DONE  (a_done)
  );

  // Instance b
  logic [15:0] b_data  = '0;
  logic        b_dc    = 1'b0;
  logic        b_valid = 1'b0;
  logic b_ready, b_sck, b_mosi, b_cs, b_dco, b_busy, b_done;

  spi_oled_tx_fifo #(
    .WIDTH     (16),
    .MSB_FIRST (0),
    .CPOL      (1)
  ) u_dut_b (
    .i_CLK   (clk),
    .i_RST   (rst),
    .i_DATA  (b_data),
    .i_DC    (b_dc),
    .i_VALID (b_valid),
    .o_READY (b_ready),
    .o_SCK   (b_sck),
    .o_MOSI  (b_mosi),
    .o_CS    (b_cs),
    .o_DC    (b_dco),
    .o_BUSY  (b_busy),
    .o_DONE  (b_done)
  );

`ifdef SPI_TX_CS_PER_WORD_EN
  localparam bit PER_WORD = 1'b1;
`else
  localparam bit PER_WORD = 1'b0;
`endif

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } word_t;

  word_t exp_q[$];
  logic  eb_q[$];
  logic  b_exp_dc = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor a: slave sampling MOSI on SCK rising edges, MSB first
  // ---------------------------------------------------------------------------
  int   a_done_cnt = 0, a_rises = 0, a_high = 0, a_cs_low = 0;
  int   a_windows = 0, a_toggles = 0, a_bits = 0;
  logic a_prev_sck = 1'b0, a_prev_cs = 1'b1;
  logic [7:0] a_shift = '0;
  word_t a_w;

  always @(negedge clk) begin
    if (rst) begin
      a_bits     = 0;
      a_prev_sck = 1'b0;
      a_prev_cs  = 1'b1;
    end else begin
      if (a_done) a_done_cnt++;
      if (!a_cs) a_cs_low++;
      if (!a_cs && a_sck) a_high++;
      if (a_prev_cs && !a_cs) a_windows++;
      if (a_sck != a_prev_sck) a_toggles++;
      if (!a_prev_sck && a_sck) begin
        a_rises++;
        check("a_cs_at_edge", a_cs, 0);
        check("a_bit_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("a_dc_in_word", a_dco, exp_q[0].dc);
          a_shift = {a_shift[6:0], a_mosi};
          a_bits++;
          if (a_bits == 8) begin
            a_w = exp_q.pop_front();
            check("a_word", a_shift, a_w.data);
            a_bits = 0;
          end
        end
      end
      a_prev_sck = a_sck;
      a_prev_cs  = a_cs;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor b: slave sampling MOSI on SCK falling edges (CPOL=1)
  // ---------------------------------------------------------------------------
  int   b_done_cnt = 0, b_falls = 0;
  logic b_prev_sck = 1'b1;
  logic b_bit;

  always @(negedge clk) begin
    if (rst) begin
      b_prev_sck = 1'b1;
    end else begin
      if (b_done) b_done_cnt++;
      if (b_prev_sck && !b_sck) begin
        b_falls++;
        check("b_cs_at_edge", b_cs, 0);
        check("b_dc_in_word", b_dco, b_exp_dc);
        check("b_bit_expected", eb_q.size() != 0, 1);
        if (eb_q.size() != 0) begin
          b_bit = eb_q.pop_front();
          check("b_bit", b_mosi, b_bit);
        end
      end
      b_prev_sck = b_sck;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers; the driver acts 1 time unit after the falling clock edge
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_a(input logic dc, input logic [7:0] data, input logic exp_ready);
    check("a_ready_before_push", a_ready, exp_ready);
    a_dc    = dc;
    a_data  = data;
    a_valid = 1'b1;
    if (exp_ready) exp_q.push_back('{dc: dc, data: data});
    step();
  endtask

  task automatic wait_idle(input int max_cycles);
    int k = 0;
    while ((a_busy || b_busy) && k < max_cycles) begin
      step();
      k++;
    end
    check("idle_within_budget", k < max_cycles, 1);
    repeat (3) step();
  endtask

  int base_done, base_rises, base_high, base_cs_low, base_windows, base_toggles;
  int base_bdone, base_bfalls;

  task automatic snapshot();
    base_done    = a_done_cnt;
    base_rises   = a_rises;
    base_high    = a_high;
    base_cs_low  = a_cs_low;
    base_windows = a_windows;
    base_toggles = a_toggles;
    base_bdone   = b_done_cnt;
    base_bfalls  = b_falls;
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    repeat (2) step();

    // Reset state
    check("rst_cs", a_cs, 1);
    check("rst_sck", a_sck, 0);
    check("rst_mosi", a_mosi, 0);
    check("rst_dc", a_dco, 0);
    check("rst_done", a_done, 0);
    check("rst_busy", a_busy, 0);
    check("rst_ready", a_ready, 1);
    check("rst_b_sck", b_sck, 1);
    rst = 1'b0;
    repeat (2) step();

    // 1: reset in the middle of a word
    snapshot();
    push_a(1'b1, 8'hA5, 1'b1);
    a_valid = 1'b0;
    k = 0;
    while ((a_toggles - base_toggles) < 3 && k < 100) begin
      step();
      k++;
    end
    check("t1_three_edges_seen", k < 100, 1);
    #1 rst = 1'b1;
    #1;
    check("t1_cs", a_cs, 1);
    check("t1_sck", a_sck, 0);
    check("t1_mosi", a_mosi, 0);
    check("t1_dc", a_dco, 0);
    check("t1_ready", a_ready, 1);
    check("t1_busy", a_busy, 0);
    check("t1_done", a_done, 0);
    exp_q.delete();
    step();
    rst = 1'b0;
    repeat (10) step();
    check("t1_cs_after", a_cs, 1);
    check("t1_busy_after", a_busy, 0);
    check("t1_no_done", a_done_cnt - base_done, 0);

    // 2: single word 0xA5, DC=0
    snapshot();
    push_a(1'b0, 8'hA5, 1'b1);
    a_valid = 1'b0;
    check("t2_cs_high_at_push_edge", a_cs, 1);
    step();
    check("t2_cs_low_next_edge", a_cs, 0);
    wait_idle(200);
    check("t2_done_pulses", a_done_cnt - base_done, 1);
    check("t2_sck_rises", a_rises - base_rises, 8);
    check("t2_sck_high_cycles", a_high - base_high, 16);
    check("t2_cs_low_cycles", a_cs_low - base_cs_low, 36);
    check("t2_cs_windows", a_windows - base_windows, 1);

    // 3: burst of three words queued before SCK starts
    snapshot();
    push_a(1'b0, 8'h00, 1'b1);
    push_a(1'b1, 8'hFF, 1'b1);
    push_a(1'b1, 8'h3C, 1'b1);
    a_valid = 1'b0;
    wait_idle(400);
    check("t3_done_pulses", a_done_cnt - base_done, 3);
    check("t3_sck_rises", a_rises - base_rises, 24);
    check("t3_sck_high_cycles", a_high - base_high, 48);
    check("t3_cs_windows", a_windows - base_windows, PER_WORD ? 3 : 1);
    check("t3_cs_low_cycles", a_cs_low - base_cs_low, PER_WORD ? 108 : 100);

    // 4: FIFO fills while the first word is on the wire
    snapshot();
    push_a(1'b1, 8'h11, 1'b1);
    a_valid = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 6; i++) begin
      push_a(i[0], 8'h20 + 8'(i), i < 4);
    end
    a_valid = 1'b0;
    check("t4_ready_after_pushes", a_ready, 0);
    wait_idle(600);
    check("t4_done_pulses", a_done_cnt - base_done, 5);
    check("t4_sck_rises", a_rises - base_rises, 40);
    check("t4_cs_windows", a_windows - base_windows, PER_WORD ? 5 : 1);
    check("t4_ready_idle", a_ready, 1);

    // 5: LSB first, CPOL=1, WIDTH=16, data 0x8001 -> bits 1, fourteen 0s, 1
    snapshot();
    check("t5_sck_idle_high", b_sck, 1);
    check("t5_b_ready", b_ready, 1);
    b_exp_dc = 1'b1;
    eb_q.push_back(1'b1);
    for (int i = 0; i < 14; i++) eb_q.push_back(1'b0);
    eb_q.push_back(1'b1);
    b_dc    = 1'b1;
    b_data  = 16'h8001;
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    wait_idle(400);
    check("t5_done_pulses", b_done_cnt - base_bdone, 1);
    check("t5_sck_falls", b_falls - base_bfalls, 16);
    check("t5_sck_idle_after", b_sck, 1);
    check("t5_cs_after", b_cs, 1);
    check("t5_bits_left", eb_q.size(), 0);

    check("a_words_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
